traffic_light_param: RTL
========================

Name: traffic_light_param

Overview:
- Parametrised single-approach traffic-light controller. Phase durations, green-blink count and counter width are set by parameters.
- Adds a night flashing-yellow mode and exposes phase/count status outputs.
- Sits at the same level as the fixed-timing light. Drives lamp outputs R/G/Y directly and feeds phase/cnt to monitors/testbenches.

Parameters:
- CW, 12, counter width in bits; must hold max(G_LONG, BLINK_HALF, Y_LEN, R_LEN, FLASH_HALF).
- G_LONG, 1024, cycles of the main green phase.
- BLINK_HALF, 128, cycles of each dark and each lit half of a green blink.
- BLINK_N, 2, number of (off, on) blink pairs after the main green; 0 means no blink phases.
- Y_LEN, 512, cycles of yellow.
- R_LEN, 1024, cycles of red.
- FLASH_HALF, 256, cycles per yellow on/off half-period in night mode.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- pass  in  1  pedestrian/priority request to force or hold green; level-sampled each clk.
- night  in  1  night mode request (flashing yellow); level-sampled each clk.
- R  out  1  red lamp.
- G  out  1  green lamp.
- Y  out  1  yellow lamp.
- phase  out  3  current state code: GREEN=0, BLINK_OFF=1, BLINK_ON=2, YELLOW=3, RED=4, FLASH=5.
- cnt  out  CW  cycle count within the current phase, 1-based.

Behaviour:
- Registered state: state, cnt, bidx (blink pair index, width ≥ clog2(BLINK_N+1)), flash_on (1 bit).
- Outputs are a combinational decode of registered state only.
  - GREEN and BLINK_ON: G=1.
  - BLINK_OFF: all lamps 0.
  - YELLOW: Y=1.
  - RED: R=1.
  - FLASH: Y=flash_on; R=G=0.
- Exactly one lamp is lit in every state except BLINK_OFF and FLASH-off, where all lamps are 0.
- Reset (sync; top priority): state=GREEN, cnt=1, bidx=0, flash_on=0. So R=0, G=1, Y=0, phase=0, cnt=1 in the cycle after the rst edge. Reset mid-phase aborts the phase immediately.
- Phase timing: each phase is entered with cnt=1 and cnt increments by 1 per clk. The phase exits on the edge where cnt==LEN, so it lasts exactly LEN cycles. The next state is entered with cnt=1.
- Normal sequence (night=0, pass=0):
  - GREEN(G_LONG) → BLINK_OFF(BLINK_HALF) → BLINK_ON(BLINK_HALF).
  - At the end of BLINK_ON: if bidx==BLINK_N-1, go to YELLOW and clear bidx; otherwise bidx+1 and go to BLINK_OFF.
  - YELLOW(Y_LEN) → RED(R_LEN) → GREEN.
  - If BLINK_N==0, GREEN goes directly to YELLOW.
- pass=1 (night=0):
  - In GREEN: state and cnt hold unchanged, including when cnt==G_LONG. The green is extended while pass stays high. When pass drops, counting resumes from the held value.
  - In BLINK_OFF, BLINK_ON, YELLOW or RED: next state is GREEN with cnt=1 and bidx=0.
- night=1: priority over pass.
  - From any non-FLASH state, the next state is FLASH with cnt=1 and flash_on=1.
  - In FLASH, cnt counts to FLASH_HALF, then flash_on toggles and cnt=1. This is a free-running square wave with period 2*FLASH_HALF.
- night 1→0 while in FLASH: next state is RED with cnt=1 (safe restart) and flash_on=0. pass is ignored on that edge.
- Priority on the same edge: rst > night > pass > timer expiry.
- Counter never wraps. cnt is bounded by the phase length, or frozen by pass.
- No combinational path from inputs to R/G/Y; lamp changes appear one cycle after the causing input is sampled.

Test Plan:
Benches override parameters to CW=6, G_LONG=8, BLINK_HALF=2, BLINK_N=2, Y_LEN=4, R_LEN=6, FLASH_HALF=3.
- rst high 1 clk, then free run for 30 cycles → phases and lamps:
  - GREEN 8 cycles, G=1.
  - BLINK_OFF 2 cycles, all lamps 0.
  - BLINK_ON 2 cycles, G=1.
  - BLINK_OFF 2 cycles, then BLINK_ON 2 cycles.
  - YELLOW 4 cycles, Y=1.
  - RED 6 cycles, R=1.
  - Back to GREEN with cnt=1 at cycle 27.
- pass=1 for 5 clks starting at GREEN cnt=5 → cnt stays 5 for the 5 clks. After pass drops, GREEN lasts 3 more cycles (8 GREEN cycles total, excluding the held cycles).
- pass pulse 1 clk during YELLOW cnt=2 → next cycle phase=0, cnt=1, G=1, bidx=0. A full blink sequence follows later.
- night=1 during RED cnt=3, held for 10 clks → FLASH, Y pattern 1,1,1,0,0,0,1,1,1,0. After night drops: RED with cnt=1, R=1.
- rst asserted together with night=1 and pass=1 during BLINK_ON → next cycle GREEN, cnt=1, G=1, flash_on=0.
- Re-run with BLINK_N=0 → GREEN cnt=8 is followed directly by YELLOW cnt=1; all lamps are never simultaneously 0 outside FLASH.

Source files
------------

// File: rtl/traffic_light_param.sv
// Parametrised single-approach traffic-light controller.
// Normal cycle: green, optional green blinks, yellow, red. A pass request
// holds or restarts green, and night mode flashes yellow. The lamps and the
// phase/cnt status outputs are decoded from registered state only.
module traffic_light_param #(
    parameter int CW         = 12,
    parameter int G_LONG     = 1024,
    parameter int BLINK_HALF = 128,
    parameter int BLINK_N    = 2,
    parameter int Y_LEN      = 512,
    parameter int R_LEN      = 1024,
    parameter int FLASH_HALF = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pass,
    input  logic          night,
    output logic          R,
    output logic          G,
    output logic          Y,
    output logic [2:0]    phase,
    output logic [CW-1:0] cnt
);

    typedef enum logic [2:0] {
        ST_GREEN     = 3'd0,
        ST_BLINK_OFF = 3'd1,
        ST_BLINK_ON  = 3'd2,
        ST_YELLOW    = 3'd3,
        ST_RED       = 3'd4,
        ST_FLASH     = 3'd5
    } state_t;

    // Blink pair index is at least one bit wide, even when blinking is disabled.
    localparam int BW = ($clog2(BLINK_N + 1) < 1) ? 1 : $clog2(BLINK_N + 1);

    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] G_END     = CW'(G_LONG);
    localparam logic [CW-1:0] BH_END    = CW'(BLINK_HALF);
    localparam logic [CW-1:0] Y_END     = CW'(Y_LEN);
    localparam logic [CW-1:0] R_END     = CW'(R_LEN);
    localparam logic [CW-1:0] FH_END    = CW'(FLASH_HALF);
    localparam logic [BW-1:0] BIDX_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BIDX_LAST = (BLINK_N > 0) ? BW'(BLINK_N - 1) : {BW{1'b0}};

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [BW-1:0] bidx_r, bidx_s;
    logic          flash_on_r, flash_on_s;

    // State register with synchronous reset back to the start of green.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_GREEN;
            cnt_r      <= CNT_ONE;
            bidx_r     <= {BW{1'b0}};
            flash_on_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            bidx_r     <= bidx_s;
            flash_on_r <= flash_on_s;
        end
    end

    // Next-state logic; priority is night, then pass, then phase timer expiry.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r + CNT_ONE;
        bidx_s     = bidx_r;
        flash_on_s = flash_on_r;
        if (night) begin
            if (state_r != ST_FLASH) begin
                // Entering night mode starts with the yellow lamp lit.
                state_s    = ST_FLASH;
                cnt_s      = CNT_ONE;
                bidx_s     = {BW{1'b0}};
                flash_on_s = 1'b1;
            end else if (cnt_r == FH_END) begin
                cnt_s      = CNT_ONE;
                flash_on_s = ~flash_on_r;
            end else begin
                cnt_s      = cnt_r + CNT_ONE;
            end
        end else if (state_r == ST_FLASH) begin
            // Leaving night mode always restarts from red as the safe phase.
            state_s    = ST_RED;
            cnt_s      = CNT_ONE;
            bidx_s     = {BW{1'b0}};
            flash_on_s = 1'b0;
        end else if (pass) begin
            if (state_r == ST_GREEN) begin
                // Green is frozen, including at its last cycle, while pass stays high.
                cnt_s = cnt_r;
            end else begin
                state_s = ST_GREEN;
                cnt_s   = CNT_ONE;
                bidx_s  = {BW{1'b0}};
            end
        end else begin
            case (state_r)
                ST_GREEN: begin
                    if (cnt_r == G_END) begin
                        state_s = (BLINK_N == 0) ? ST_YELLOW : ST_BLINK_OFF;
                        cnt_s   = CNT_ONE;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_BLINK_OFF: begin
                    if (cnt_r == BH_END) begin
                        state_s = ST_BLINK_ON;
                        cnt_s   = CNT_ONE;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_BLINK_ON: begin
                    if (cnt_r == BH_END) begin
                        cnt_s = CNT_ONE;
                        if (bidx_r == BIDX_LAST) begin
                            state_s = ST_YELLOW;
                            bidx_s  = {BW{1'b0}};
                        end else begin
                            state_s = ST_BLINK_OFF;
                            bidx_s  = bidx_r + BIDX_ONE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_YELLOW: begin
                    if (cnt_r == Y_END) begin
                        state_s = ST_RED;
                        cnt_s   = CNT_ONE;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_RED: begin
                    if (cnt_r == R_END) begin
                        state_s = ST_GREEN;
                        cnt_s   = CNT_ONE;
                    end else begin
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    // Unreachable encodings recover through red.
                    state_s    = ST_RED;
                    cnt_s      = CNT_ONE;
                    bidx_s     = {BW{1'b0}};
                    flash_on_s = 1'b0;
                end
            endcase
        end
    end

    // Lamp decode from registered state; at most one lamp is ever lit.
    always_comb begin
        R = 1'b0;
        G = 1'b0;
        Y = 1'b0;
        case (state_r)
            ST_GREEN:     G = 1'b1;
            ST_BLINK_OFF: G = 1'b0;
            ST_BLINK_ON:  G = 1'b1;
            ST_YELLOW:    Y = 1'b1;
            ST_RED:       R = 1'b1;
            ST_FLASH:     Y = flash_on_r;
            default:      R = 1'b1;
        endcase
    end

    assign phase = state_r;
    assign cnt   = cnt_r;

endmodule
